// File: rtl/pwm_csr_pkg.sv
// pwm_csr_pkg
//   Definitions shared by the PWM CSR initiator (pwm_csr_master) and the
//   PWM CSR responder:
//     - CSR word addresses (control, status, period, duty, divisor)
//     - sequence result codes
//     - initiator FSM state encoding
//     - cfg_is_bad(): the configuration sanity rule applied before any bus cycle
package pwm_csr_pkg;

    // CSR map
    localparam logic [2:0] ADDR_CTRL = 3'd0;
    localparam logic [2:0] ADDR_STAT = 3'd1;
    localparam logic [2:0] ADDR_PER  = 3'd2;
    localparam logic [2:0] ADDR_DUTY = 3'd3;
    localparam logic [2:0] ADDR_DIV  = 3'd4;

    // Result codes
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_CFG     = 2'b01;
    localparam logic [1:0] ERR_RDBK    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Initiator FSM state encoding
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_DIS   = 4'd1;
    localparam logic [3:0] ST_WR_PER   = 4'd2;
    localparam logic [3:0] ST_WR_DUTY  = 4'd3;
    localparam logic [3:0] ST_WR_DIV   = 4'd4;
    localparam logic [3:0] ST_WR_EN    = 4'd5;
    localparam logic [3:0] ST_RD_PER   = 4'd6;
    localparam logic [3:0] ST_CMP_PER  = 4'd7;
    localparam logic [3:0] ST_RD_DUTY  = 4'd8;
    localparam logic [3:0] ST_CMP_DUTY = 4'd9;
    localparam logic [3:0] ST_RD_DIV   = 4'd10;
    localparam logic [3:0] ST_CMP_DIV  = 4'd11;
    localparam logic [3:0] ST_RD_STAT  = 4'd12;
    localparam logic [3:0] ST_CMP_STAT = 4'd13;
    localparam logic [3:0] ST_WR_ABORT = 4'd14;
    localparam logic [3:0] ST_DONE     = 4'd15;

    // A zero period, or a duty longer than the period, cannot be programmed.
    function automatic logic cfg_is_bad(input logic [15:0] period,
                                        input logic [15:0] duty);
        return (period == 16'd0) || (duty > period);
    endfunction

endpackage

// File: rtl/pwm_csr_master.sv
// pwm_csr_master
//   Programs a PWM peripheral over an Avalon-MM CSR port: disables it, writes
//   period/duty/divisor, writes the enable bit, reads back and checks the three
//   settings, then polls status bit 0 until it equals the requested enable.
//   Ports:
//     clk, reset                 clock; asynchronous active-high reset
//     start                      one-cycle request, only honoured in IDLE
//     cfg_enable/period/duty/prescaler  settings, latched on accepted start
//     busy, done, err_code       sequence status and result
//     chipselect/write/read/address/writedata/readdata  CSR bus (readdata
//                                valid one cycle after the read strobe)
module pwm_csr_master
    import pwm_csr_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cfg_enable,
    input  logic [15:0] cfg_period,
    input  logic [15:0] cfg_duty,
    input  logic [15:0] cfg_prescaler,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic        chipselect,
    output logic        write,
    output logic        read,
    output logic [2:0]  address,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    localparam logic [15:0] POLL_LIMIT_W = 16'(POLL_LIMIT);

    logic [3:0]  state_reg, state_next;
    logic [1:0]  err_reg, err_next;
    logic [15:0] poll_reg, poll_next;
    logic        en_reg;
    logic [15:0] per_reg, duty_reg, div_reg;
    logic        accept;
    logic [15:0] poll_inc;

    assign accept   = (state_reg == ST_IDLE) && start;
    assign poll_inc = poll_reg + 16'd1;

    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        poll_next  = poll_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    poll_next = 16'd0;
                    if (cfg_is_bad(cfg_period, cfg_duty)) begin
                        err_next   = ERR_CFG;
                        state_next = ST_DONE;
                    end else begin
                        err_next   = ERR_OK;
                        state_next = ST_WR_DIS;
                    end
                end
            end
            ST_WR_DIS:  state_next = ST_WR_PER;
            ST_WR_PER:  state_next = ST_WR_DUTY;
            ST_WR_DUTY: state_next = ST_WR_DIV;
            ST_WR_DIV:  state_next = ST_WR_EN;
            ST_WR_EN:   state_next = ST_RD_PER;
            ST_RD_PER:  state_next = ST_CMP_PER;
            ST_CMP_PER: begin
                if (readdata != {16'b0, per_reg}) begin
                    err_next   = ERR_RDBK;
                    state_next = ST_WR_ABORT;
                end else begin
                    state_next = ST_RD_DUTY;
                end
            end
            ST_RD_DUTY: state_next = ST_CMP_DUTY;
            ST_CMP_DUTY: begin
                if (readdata != {16'b0, duty_reg}) begin
                    err_next   = ERR_RDBK;
                    state_next = ST_WR_ABORT;
                end else begin
                    state_next = ST_RD_DIV;
                end
            end
            ST_RD_DIV:  state_next = ST_CMP_DIV;
            ST_CMP_DIV: begin
                if (readdata != {16'b0, div_reg}) begin
                    err_next   = ERR_RDBK;
                    state_next = ST_WR_ABORT;
                end else begin
                    state_next = ST_RD_STAT;
                end
            end
            ST_RD_STAT: state_next = ST_CMP_STAT;
            ST_CMP_STAT: begin
                if (readdata[0] == en_reg) begin
                    err_next   = ERR_OK;
                    state_next = ST_DONE;
                end else begin
                    // poll_inc is the number of status reads done so far
                    poll_next = poll_inc;
                    if (poll_inc >= POLL_LIMIT_W) begin
                        err_next   = ERR_TIMEOUT;
                        state_next = ST_WR_ABORT;
                    end else begin
                        state_next = ST_RD_STAT;
                    end
                end
            end
            ST_WR_ABORT: state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            err_reg   <= ERR_OK;
            poll_reg  <= 16'd0;
            en_reg    <= 1'b0;
            per_reg   <= 16'd0;
            duty_reg  <= 16'd0;
            div_reg   <= 16'd0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            poll_reg  <= poll_next;
            if (accept) begin
                en_reg   <= cfg_enable;
                per_reg  <= cfg_period;
                duty_reg <= cfg_duty;
                div_reg  <= cfg_prescaler;
            end
        end
    end

    // Bus strobes are a pure decode of the state, so reset clears them at once.
    always_comb begin
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = ADDR_CTRL;
        writedata  = 32'd0;
        case (state_reg)
            ST_WR_DIS, ST_WR_ABORT: begin
                chipselect = 1'b1;
                write      = 1'b1;
            end
            ST_WR_PER: begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = ADDR_PER;
                writedata  = {16'b0, per_reg};
            end
            ST_WR_DUTY: begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = ADDR_DUTY;
                writedata  = {16'b0, duty_reg};
            end
            ST_WR_DIV: begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = ADDR_DIV;
                writedata  = {16'b0, div_reg};
            end
            ST_WR_EN: begin
                chipselect = 1'b1;
                write      = 1'b1;
                writedata  = {31'b0, en_reg};
            end
            ST_RD_PER: begin
                chipselect = 1'b1;
                read       = 1'b1;
                address    = ADDR_PER;
            end
            ST_RD_DUTY: begin
                chipselect = 1'b1;
                read       = 1'b1;
                address    = ADDR_DUTY;
            end
            ST_RD_DIV: begin
                chipselect = 1'b1;
                read       = 1'b1;
                address    = ADDR_DIV;
            end
            ST_RD_STAT: begin
                chipselect = 1'b1;
                read       = 1'b1;
                address    = ADDR_STAT;
            end
            default: begin
                chipselect = 1'b0;
            end
        endcase
    end

    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign err_code = err_reg;

endmodule

// File: tb/tb_pwm_csr_master.sv
// tb_pwm_csr_master
//   Drives directed programming requests into pwm_csr_master (POLL_LIMIT=3)
//   attached to a small CSR responder model. A transaction-level model turns
//   each request into the expected per-cycle bus/status trace; one compare
//   process checks the DUT against that trace every cycle it is populated.
module tb_pwm_csr_master;
    import pwm_csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [15:0] cfg_period = 16'd0, cfg_duty = 16'd0, cfg_prescaler = 16'd0;
    logic        busy, done, chipselect, write, read;
    logic [1:0]  err_code;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata = 32'd0;

    always #5 clk = ~clk;

    pwm_csr_master #(.POLL_LIMIT(3)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_enable(cfg_enable), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .cfg_prescaler(cfg_prescaler), .busy(busy), .done(done), .err_code(err_code),
        .chipselect(chipselect), .write(write), .read(read), .address(address),
        .writedata(writedata), .readdata(readdata)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- responder model ----------------
    logic [31:0] regs [0:7];
    bit          corrupt_per = 0;   // period readback returns 999
    bit          stuck_stat  = 0;   // pwm_running stuck at 0
    logic [2:0]  wl_addr [$];
    logic [31:0] wl_data [$];
    int          st_reads = 0;
    int          bus_cycles = 0;

    initial for (int i = 0; i < 8; i++) regs[i] = 32'd0;

    always @(posedge clk) begin
        if (chipselect) bus_cycles++;
        if (chipselect && write) begin
            regs[address] <= writedata;
            wl_addr.push_back(address);
            wl_data.push_back(writedata);
        end
        if (chipselect && read) begin
            if (address == ADDR_STAT) begin
                st_reads++;
                readdata <= stuck_stat ? 32'd0 : {31'b0, regs[ADDR_CTRL][0]};
            end else if (address == ADDR_PER && corrupt_per) begin
                readdata <= 32'd999;
            end else begin
                readdata <= regs[address];
            end
        end
    end

    // ---------------- expected trace model ----------------
    typedef struct packed {
        logic       cs, wr, rd;
        logic [2:0] addr;
        logic [31:0] wd;
        logic       busy, done, chk_err;
        logic [1:0] err;
    } rec_t;

    rec_t exp_q [$];
    int   cyc_no = 0;

    function automatic void push(logic cs, logic wr, logic rd, logic [2:0] a,
                                 logic [31:0] wd, logic b, logic d, logic ce,
                                 logic [1:0] e);
        rec_t r;
        r.cs = cs; r.wr = wr; r.rd = rd; r.addr = a; r.wd = wd;
        r.busy = b; r.done = d; r.chk_err = ce; r.err = e;
        exp_q.push_back(r);
    endfunction

    function automatic void p_wr(logic [2:0] a, logic [31:0] wd);
        push(1, 1, 0, a, wd, 1, 0, 0, 2'b00);
    endfunction

    function automatic void p_rd(logic [2:0] a);
        push(1, 0, 1, a, 32'd0, 1, 0, 0, 2'b00);
        push(0, 0, 0, 3'd0, 32'd0, 1, 0, 0, 2'b00);   // compare cycle
    endfunction

    // Builds the trace for one accepted request. Returns the 1-based cycle
    // (counted from the start edge) in which done is expected.
    function automatic int model(logic en, logic [15:0] per, logic [15:0] duty,
                                 logic [15:0] div, bit corrupt, bit stuck, int limit);
        logic [1:0] e;
        bit ok;
        logic [31:0] rb [3];
        logic [31:0] want [3];
        logic [2:0]  ad [3];
        int status_val;
        exp_q.delete();
        if (per == 0 || duty > per) begin
            e = 2'b01;
        end else begin
            p_wr(3'd0, 32'd0);
            p_wr(3'd2, {16'b0, per});
            p_wr(3'd3, {16'b0, duty});
            p_wr(3'd4, {16'b0, div});
            p_wr(3'd0, {31'b0, en});
            want[0] = {16'b0, per};  want[1] = {16'b0, duty};  want[2] = {16'b0, div};
            ad[0] = 3'd2; ad[1] = 3'd3; ad[2] = 3'd4;
            rb[0] = corrupt ? 32'd999 : want[0];
            rb[1] = want[1];
            rb[2] = want[2];
            ok = 1;
            for (int k = 0; k < 3 && ok; k++) begin
                p_rd(ad[k]);
                if (rb[k] != want[k]) ok = 0;
            end
            if (!ok) begin
                e = 2'b10;
                p_wr(3'd0, 32'd0);
            end else begin
                status_val = stuck ? 0 : int'(en);
                e = 2'b11;
                for (int n = 1; n <= limit; n++) begin
                    p_rd(3'd1);
                    if (status_val == int'(en)) begin
                        e = 2'b00;
                        break;
                    end
                end
                if (e == 2'b11) p_wr(3'd0, 32'd0);
            end
        end
        push(0, 0, 0, 3'd0, 32'd0, 1, 1, 1, e);
        model = exp_q.size();
        for (int t = 0; t < 3; t++) push(0, 0, 0, 3'd0, 32'd0, 0, 0, 1, e);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        rec_t r;
        bit ok;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            cyc_no++;
            ok = (chipselect == r.cs) && (write == r.wr) && (read == r.rd) &&
                 (busy == r.busy) && (done == r.done) &&
                 (!r.cs || address == r.addr) && (!r.wr || writedata == r.wd) &&
                 (!r.chk_err || err_code == r.err);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL trace cyc=%0d got cs%0b wr%0b rd%0b a%0d wd%0d busy%0b done%0b err%0d want cs%0b wr%0b rd%0b a%0d wd%0d busy%0b done%0b err%0d",
                         cyc_no, chipselect, write, read, address, writedata, busy, done, err_code,
                         r.cs, r.wr, r.rd, r.addr, r.wd, r.busy, r.done, r.err);
            end
        end
    end

    task automatic check(string name, longint act, longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic drive_start(logic en, logic [15:0] per, logic [15:0] duty, logic [15:0] div);
        @(posedge clk); #1;
        start = 1; cfg_enable = en; cfg_period = per; cfg_duty = duty; cfg_prescaler = div;
        wl_addr.delete(); wl_data.delete(); st_reads = 0; bus_cycles = 0;
        @(posedge clk); #1;     // start edge
        start = 0;
        cyc_no = 0;
    endtask

    task automatic drain(string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL %s timeout got=%0d records left want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_wlog(string name, int idx, int a, int d);
        if (idx >= wl_addr.size()) begin
            check({name, "_present"}, wl_addr.size(), idx + 1);
        end else begin
            check({name, "_addr"}, wl_addr[idx], a);
            check({name, "_data"}, wl_data[idx], d);
        end
    endtask

    int di;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_strobes", {chipselect, write, read}, 0);
        check("rst_err", err_code, 0);
        check("rst_addr_wd", {address, writedata}, 0);
        reset = 0;

        // 1: normal programming, status matches on first poll
        drive_start(1, 16'd1000, 16'd250, 16'd4);
        di = model(1, 16'd1000, 16'd250, 16'd4, 0, 0, 3);
        check("s1_model_done_cycle", di, 14);
        drain("s1");
        check("s1_nwrites", wl_addr.size(), 5);
        check_wlog("s1_w0", 0, 0, 0);
        check_wlog("s1_w1", 1, 2, 1000);
        check_wlog("s1_w2", 2, 3, 250);
        check_wlog("s1_w3", 3, 4, 4);
        check_wlog("s1_w4", 4, 0, 1);
        check("s1_err_held", err_code, 0);
        $display("txn s1 enable=1 period=1000 duty=250 div=4 err=%0d", err_code);

        // 2: duty > period, rejected without bus traffic
        drive_start(1, 16'd1000, 16'd1001, 16'd4);
        di = model(1, 16'd1000, 16'd1001, 16'd4, 0, 0, 3);
        check("s2_model_done_cycle", di, 1);
        drain("s2");
        check("s2_bus_cycles", bus_cycles, 0);
        check("s2_err_held", err_code, 1);
        $display("txn s2 duty=1001 period=1000 err=%0d", err_code);

        // 3: period readback corrupted
        corrupt_per = 1;
        drive_start(1, 16'd1000, 16'd250, 16'd4);
        di = model(1, 16'd1000, 16'd250, 16'd4, 1, 0, 3);
        check("s3_model_done_cycle", di, 9);
        drain("s3");
        corrupt_per = 0;
        check("s3_nwrites", wl_addr.size(), 6);
        check_wlog("s3_abort", 5, 0, 0);
        check("s3_err_held", err_code, 2);
        $display("txn s3 period readback 999 err=%0d", err_code);

        // 4: status never matches -> timeout after 3 reads
        stuck_stat = 1;
        drive_start(1, 16'd1000, 16'd250, 16'd4);
        di = model(1, 16'd1000, 16'd250, 16'd4, 0, 1, 3);
        check("s4_model_done_cycle", di, 19);
        drain("s4");
        stuck_stat = 0;
        check("s4_status_reads", st_reads, 3);
        check_wlog("s4_abort", 5, 0, 0);
        check("s4_err_held", err_code, 3);
        $display("txn s4 status stuck err=%0d", err_code);

        // 5: reset in WR_DUTY
        drive_start(1, 16'd1000, 16'd250, 16'd4);
        @(posedge clk); #1;           // WR_PER
        @(posedge clk); #1;           // WR_DUTY
        check("s5_in_wr_duty", {chipselect, write, read, address}, {3'b110, 3'd3});
        reset = 1;
        #1;
        check("s5_strobes", {chipselect, write, read}, 0);
        check("s5_busy", busy, 0);
        check("s5_done_err", {done, err_code}, 0);
        @(posedge clk); #1;
        reset = 0;
        bus_cycles = 0;
        repeat (20) @(posedge clk);
        #1;
        check("s5_no_bus_after_reset", bus_cycles, 0);
        $display("txn s5 reset during WR_DUTY busy=%0b", busy);

        // 6: second start while busy, with changed cfg, is ignored
        drive_start(0, 16'd500, 16'd100, 16'd7);
        di = model(0, 16'd500, 16'd100, 16'd7, 0, 0, 3);
        @(posedge clk); #1;
        start = 1; cfg_enable = 1; cfg_period = 16'd0; cfg_duty = 16'd9; cfg_prescaler = 16'd9;
        @(posedge clk); #1;
        start = 0;
        drain("s6");
        check("s6_nwrites", wl_addr.size(), 5);
        check_wlog("s6_w1", 1, 2, 500);
        check_wlog("s6_w2", 2, 3, 100);
        check_wlog("s6_w3", 3, 4, 7);
        check_wlog("s6_w4", 4, 0, 0);
        check("s6_err", err_code, 0);
        $display("txn s6 start while busy ignored err=%0d", err_code);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
